// File: rtl/decode_sequencer.sv
// decode_sequencer
//   Issues fetched or forced opcodes to an execute unit. Each accepted opcode
//   is split into instruction/params and a combined delay/side-set field; the
//   side-set is strobed on the first execute cycle and the delay is spent as
//   idle cycles after the instruction completes.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   in_enable              : 0 freezes the sequencer and silences its handshakes
//   in_smPinCtrl[31:29]    : side-set bit count
//   in_smExecCtrl[30:29]   : side-set optional enable / side-set targets pindirs
//   in_valid, in_opCode    : fetched opcode, consumed when out_ready & ~out_forceAccept
//   out_ready              : an opcode can be taken this cycle
//   in_forceValid/Opcode   : forced opcode, has priority over the fetched one
//   out_forceAccept        : the forced opcode was taken this cycle
//   in_stall               : execute unit holds the current instruction
//   in_flush               : drop the current instruction and any delay
//   out_execValid          : instruction presented to execute
//   out_instruction        : opcode bits [15:13]
//   out_instructionParams  : opcode bits [7:0]
//   out_sideSet            : side-set value, LSB-aligned
//   out_sideStrobe         : apply the side-set this cycle
//   out_sidePindir         : side-set targets pindirs
//   out_delayActive        : delay countdown in progress
module decode_sequencer #(
   parameter int OPCODE_W  = 16,
   parameter int FIELD_LSB = 8,
   parameter int FIELD_W   = 5,
   parameter int CNT_W     = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_enable,
   input  logic [31:0]         in_smPinCtrl,
   input  logic [31:0]         in_smExecCtrl,
   input  logic                in_valid,
   input  logic [OPCODE_W-1:0] in_opCode,
   output logic                out_ready,
   input  logic                in_forceValid,
   input  logic [OPCODE_W-1:0] in_forceOpcode,
   output logic                out_forceAccept,
   input  logic                in_stall,
   input  logic                in_flush,
   output logic                out_execValid,
   output logic [2:0]          out_instruction,
   output logic [7:0]          out_instructionParams,
   output logic [FIELD_W-1:0]  out_sideSet,
   output logic                out_sideStrobe,
   output logic                out_sidePindir,
   output logic                out_delayActive
);

   typedef enum logic [1:0] {IDLE, EXEC, DELAY} state_t;

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic [2:0]         instr_q;
   logic [7:0]         params_q;
   logic [FIELD_W-1:0] side_q;
   logic [FIELD_W-1:0] delay_q;
   logic               side_en_q;
   logic               pindir_q;
   logic               strobe_done;

   logic [OPCODE_W-1:0] sel_op;
   logic [FIELD_W-1:0]  field;
   logic [FIELD_W-1:0]  side_d;
   logic [FIELD_W-1:0]  delay_d;
   logic                side_en_d;
   logic [31:0]         cnt_c;
   logic [31:0]         dcnt_c;

   logic complete;
   logic ready_c;
   logic accept;

   // Field decode of whichever opcode would be taken this cycle.
   always_comb begin
      sel_op = in_forceValid ? in_forceOpcode : in_opCode;
      field  = sel_op[FIELD_LSB +: FIELD_W];
      cnt_c  = {29'd0, in_smPinCtrl[31:29]};
      if (cnt_c > 32'(FIELD_W)) cnt_c = 32'(FIELD_W);
      dcnt_c    = 32'(FIELD_W) - cnt_c;
      side_d    = field >> dcnt_c;
      delay_d   = field & FIELD_W'((32'd1 << dcnt_c) - 32'd1);
      side_en_d = (cnt_c != 32'd0);
      // Optional side-set: the top side bit is the enable, not part of the value.
      if (in_smExecCtrl[30] && cnt_c != 32'd0) begin
         side_en_d = field[FIELD_W-1];
         side_d    = side_d & ~FIELD_W'(32'd1 << (cnt_c - 32'd1));
      end
   end

   // Handshake: ready in IDLE, on a zero-delay completion, and on the last delay cycle.
   always_comb begin
      complete = (state == EXEC) && !in_stall;
      ready_c  = 1'b0;
      if (!reset && in_enable && !in_flush) begin
         case (state)
            IDLE:    ready_c = 1'b1;
            EXEC:    ready_c = complete && (delay_q == '0);
            DELAY:   ready_c = (count == CNT_W'(1));
            default: ready_c = 1'b0;
         endcase
      end
      accept = ready_c && (in_forceValid || in_valid);
   end

   assign out_ready       = ready_c;
   assign out_forceAccept = accept && in_forceValid;
   assign out_execValid   = !reset && in_enable && (state == EXEC);
   // strobe_done keeps a stall or an enable gap from re-firing the side-set.
   assign out_sideStrobe  = !reset && in_enable && !in_flush && (state == EXEC)
                            && side_en_q && !strobe_done;
   assign out_delayActive = !reset && (state == DELAY);
   assign out_instruction       = reset ? '0 : instr_q;
   assign out_instructionParams = reset ? '0 : params_q;
   assign out_sideSet           = reset ? '0 : side_q;
   assign out_sidePindir        = !reset && pindir_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         instr_q     <= '0;
         params_q    <= '0;
         side_q      <= '0;
         delay_q     <= '0;
         side_en_q   <= 1'b0;
         pindir_q    <= 1'b0;
         strobe_done <= 1'b0;
      end else if (in_flush) begin
         state <= IDLE;
         count <= '0;
      end else if (in_enable) begin
         if (accept) begin
            state       <= EXEC;
            count       <= '0;
            strobe_done <= 1'b0;
            instr_q     <= sel_op[15:13];
            params_q    <= sel_op[7:0];
            side_q      <= side_d;
            delay_q     <= delay_d;
            side_en_q   <= side_en_d;
            pindir_q    <= in_smExecCtrl[29];
         end else begin
            case (state)
               EXEC: begin
                  strobe_done <= 1'b1;
                  if (complete) begin
                     if (delay_q != '0) begin
                        count <= CNT_W'(delay_q);
                        state <= DELAY;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
               DELAY: begin
                  count <= count - CNT_W'(1);
                  if (count == CNT_W'(1)) state <= IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   logic unused_bits;
   assign unused_bits = ^{in_smPinCtrl[28:0], in_smExecCtrl[31], in_smExecCtrl[28:0], sel_op};

endmodule

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter OPCODE_W, default 16, SHALL set the opcode width.
REQ-003 Parameter FIELD_LSB, default 8, SHALL set the LSB of the combined delay/side-set field.
REQ-004 Parameter FIELD_W, default 5, SHALL set the width of the combined delay/side-set field.
REQ-005 Parameter CNT_W, default 5, SHALL set the delay counter width, which SHALL be at least FIELD_W.
REQ-006 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_enable  in  1  state machine enabled
- in_smPinCtrl  in  32  bits [31:29] are SIDESET_COUNT
- in_smExecCtrl  in  32  bit 30 is SIDE_EN; bit 29 is SIDE_PINDIR
- in_valid  in  1  fetched opcode valid
- in_opCode  in  OPCODE_W  fetched opcode
- out_ready  out  1  fetched opcode accepted when high together with in_valid
- in_forceValid  in  1  forced (EXEC) opcode request
- in_forceOpcode  in  OPCODE_W  forced opcode
- out_forceAccept  out  1  one-cycle pulse when the forced opcode is taken
- in_stall  in  1  execute unit cannot complete the current instruction
- in_flush  in  1  abort the current instruction and any delay
- out_execValid  out  1  an instruction is presented to execute
- out_instruction  out  3  opcode bits [15:13]
- out_instructionParams  out  8  opcode bits [7:0]
- out_sideSet  out  FIELD_W  side-set value, LSB-aligned
- out_sideStrobe  out  1  apply the side-set this cycle
- out_sidePindir  out  1  side-set targets pindirs (registered copy of SIDE_PINDIR)
- out_delayActive  out  1  a delay countdown is in progress

Function
REQ-007 Field decode: with cnt = min(SIDESET_COUNT, FIELD_W) and dcnt = FIELD_W - cnt, side = field >> dcnt and delay = field & ((1 << dcnt) - 1).
REQ-008 If SIDE_EN=1 and cnt>0, the side-set is optional: field MSB SHALL be the enable bit and sideSet = side with its bit (cnt-1) cleared; if SIDE_EN=0, the side-set SHALL be enabled whenever cnt>0; if cnt=0, the side-set SHALL never be enabled.
REQ-009 Decoded fields, the side-set enable and SIDE_PINDIR SHALL be registered on accept; later changes to the CTRL inputs SHALL NOT affect an accepted instruction.
REQ-010 The state machine SHALL have states IDLE, EXEC and DELAY.
REQ-011 IDLE: out_ready=1; on accept go to EXEC.
REQ-012 EXEC: out_execValid=1; out_sideStrobe SHALL be high on the first EXEC cycle only, if side-set is enabled, and it SHALL fire even while stalled.
REQ-013 Completion SHALL mean EXEC with in_stall=0.
REQ-014 On completion with delay>0, the block SHALL load the counter with delay and go to DELAY.
REQ-015 On completion with delay=0, out_ready=1 that cycle, giving back-to-back issue at 1 instruction per cycle; the block SHALL go to EXEC if it accepts, else to IDLE.
REQ-016 DELAY: out_delayActive=1, out_execValid=0, and the counter SHALL decrement each cycle; out_ready=1 when counter==1; the next state SHALL be EXEC on accept, else IDLE; exactly delay idle cycles SHALL elapse.
REQ-017 Accept SHALL mean out_ready and (in_forceValid or in_valid); in_forceValid SHALL have priority.
REQ-018 When the forced opcode is taken, out_forceAccept=1 and the fetched opcode SHALL NOT be consumed, even if in_valid=1 (out_ready is still 1; fetch SHALL qualify it with ~out_forceAccept).
REQ-019 in_flush=1 SHALL take the block to IDLE next cycle, clear the counter, and suppress accept and sideStrobe that cycle; flush SHALL have priority over everything except reset.
REQ-020 in_enable=0 SHALL freeze the state and counter and force out_ready, out_execValid, out_sideStrobe and out_forceAccept to 0; resuming SHALL NOT re-fire a strobe already issued.
REQ-021 For FIELD_W=5, SIDESET_COUNT values 6 and 7 SHALL be clamped to 5, giving no delay bits.

Reset
REQ-022 Reset SHALL force state IDLE, counter 0, all registered fields 0, and all outputs 0 except out_ready, which SHALL be 1 the cycle after reset deasserts.
REQ-023 Reset asserted mid-EXEC or mid-DELAY SHALL abandon the instruction with no strobe and no delay.

Verification
REQ-024 Inputs cnt=2, SIDE_EN=0, opcode 16'hB800 (field 11000) -> sideSet=3, strobe on the first EXEC cycle, delay=0, next opcode accepted the same completion cycle.
REQ-025 Inputs cnt=3, SIDE_EN=1, field 10101 -> sideSet=1 with strobe, delay=1, exactly 1 DELAY cycle; field 00101 -> no strobe.
REQ-026 An instruction with delay=3 and in_stall held 4 cycles -> 1 strobe, execValid for 5 cycles, 3 DELAY cycles, then out_ready.
REQ-027 in_forceValid and in_valid asserted together in IDLE -> forced opcode issued, forceAccept=1, fetched opcode still pending next cycle.
REQ-028 in_flush during DELAY with count 5 -> IDLE next cycle, out_delayActive=0; in_enable=0 during stall -> outputs low and state held.
REQ-029 cnt=7 with FIELD_W=5 -> delay always 0 and sideSet equal to the full field.
